// File: rtl/xor_pkg.sv
// Shared types and helpers for the XOR parity gate family.
package xor_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  localparam logic MODE_GEN = 1'b0;
  localparam logic MODE_CHK = 1'b1;

  // Counter must hold FRAME_LEN+1 (check-mode frame length) without wrapping.
  function automatic int unsigned cnt_width(input int unsigned frame_len);
    return $clog2(frame_len + 2);
  endfunction

endpackage

// File: rtl/xor_reduce.sv
// Parametrised reduction XOR; combinational, reusable across the gate library.
module xor_reduce #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_data,
  output logic             o_red_c
);

  // Single-bit XOR of every input bit.
  always_comb begin
    o_red_c = ^i_data;
  end

endmodule

// File: rtl/xor_frame_parity.sv
// Streaming frame column-parity generator/checker, one word per cycle.
module xor_frame_parity
  import xor_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned ODD       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_check,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_parity,
  output logic             out_bit,
  output logic             out_err,
  output logic             busy
);

  localparam int unsigned   CW      = cnt_width(FRAME_LEN);
  localparam logic [CW-1:0] GEN_LEN = CW'(FRAME_LEN);
  localparam logic [CW-1:0] CHK_LEN = CW'(FRAME_LEN + 1);

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_acc, w_acc_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_mode, w_mode_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic [WIDTH-1:0] r_out_parity, w_out_parity_nxt;
  logic             r_out_bit, w_out_bit_nxt;
  logic             r_out_err, w_out_err_nxt;

  // Values the frame would take if the current word is accepted.
  logic [WIDTH-1:0] w_word_acc;
  logic             w_word_mode;
  logic [CW-1:0]    w_word_cnt;
  logic             w_last;
  logic             w_red;

  // First word seeds the frame; later words fold into the accumulator.
  always_comb begin
    w_word_acc  = r_acc ^ in_data;
    w_word_mode = r_mode;
    w_word_cnt  = r_cnt + CW'(1);
    if (r_state == IDLE) begin
      w_word_acc  = in_data;
      w_word_mode = in_check;
      w_word_cnt  = CW'(1);
    end
    w_last = (w_word_cnt == ((w_word_mode == MODE_CHK) ? CHK_LEN : GEN_LEN));
  end

  xor_reduce #(
    .WIDTH (WIDTH)
  ) u_reduce (
    .i_data  (w_word_acc),
    .o_red_c (w_red)
  );

  // Next-state and result logic; flush beats a simultaneous word.
  always_comb begin
    w_state_nxt      = r_state;
    w_acc_nxt        = r_acc;
    w_cnt_nxt        = r_cnt;
    w_mode_nxt       = r_mode;
    w_out_valid_nxt  = 1'b0;
    w_out_parity_nxt = r_out_parity;
    w_out_bit_nxt    = r_out_bit;
    w_out_err_nxt    = r_out_err;

    if (flush) begin
      w_state_nxt = IDLE;
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
    end else if (in_valid) begin
      w_acc_nxt  = w_word_acc;
      w_mode_nxt = w_word_mode;
      if (w_last) begin
        w_state_nxt      = IDLE;
        w_cnt_nxt        = '0;
        w_out_valid_nxt  = 1'b1;
        w_out_parity_nxt = w_word_acc;
        w_out_bit_nxt    = w_red ^ 1'(ODD);
        w_out_err_nxt    = w_word_mode & (|w_word_acc);
      end else begin
        w_state_nxt = ACCUM;
        w_cnt_nxt   = w_word_cnt;
      end
    end
  end

  // State and result registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_mode       <= MODE_GEN;
      r_out_valid  <= 1'b0;
      r_out_parity <= '0;
      r_out_bit    <= 1'b0;
      r_out_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_acc        <= w_acc_nxt;
      r_cnt        <= w_cnt_nxt;
      r_mode       <= w_mode_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_out_parity <= w_out_parity_nxt;
      r_out_bit    <= w_out_bit_nxt;
      r_out_err    <= w_out_err_nxt;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_parity = r_out_parity;
  assign out_bit    = r_out_bit;
  assign out_err    = r_out_err;
  assign busy       = (r_cnt != '0);

endmodule

// File: tb/tb_xor_frame_parity.sv
// Self-checking bench: queue-based frame model plus directed literal checks.
module tb_xor_frame_parity;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned FRAME_LEN = 4;
  localparam int unsigned ODD       = 0;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_check;
  logic             flush;
  logic             out_valid;
  logic [WIDTH-1:0] out_parity;
  logic             out_bit;
  logic             out_err;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  xor_frame_parity #(
    .WIDTH     (WIDTH),
    .FRAME_LEN (FRAME_LEN),
    .ODD       (ODD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_check   (in_check),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_parity (out_parity),
    .out_bit    (out_bit),
    .out_err    (out_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is simply the list of accepted words.
  logic [WIDTH-1:0] q_words[$];
  logic             m_mode;
  logic             exp_valid;
  logic [WIDTH-1:0] exp_par;
  logic             exp_bit;
  logic             exp_err;
  logic             exp_busy;

  always @(posedge clk or posedge rst) begin
    logic [WIDTH-1:0] x;
    if (rst) begin
      q_words.delete();
      m_mode    = 1'b0;
      exp_valid = 1'b0;
      exp_par   = '0;
      exp_bit   = 1'b0;
      exp_err   = 1'b0;
    end else begin
      exp_valid = 1'b0;
      if (flush) begin
        q_words.delete();
      end else if (in_valid) begin
        if (q_words.size() == 0) m_mode = in_check;
        q_words.push_back(in_data);
        if (q_words.size() == FRAME_LEN + (m_mode ? 1 : 0)) begin
          x = '0;
          foreach (q_words[i]) x = x ^ q_words[i];
          exp_valid = 1'b1;
          exp_par   = x;
          exp_bit   = (^x) ^ 1'(ODD);
          exp_err   = m_mode && (x != '0);
          q_words.delete();
        end
      end
    end
    exp_busy = (q_words.size() != 0);
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("cmp_valid", 32'(out_valid), 32'(exp_valid));
      chk("cmp_parity", 32'(out_parity), 32'(exp_par));
      chk("cmp_bit", 32'(out_bit), 32'(exp_bit));
      chk("cmp_err", 32'(out_err), 32'(exp_err));
      chk("cmp_busy", 32'(busy), 32'(exp_busy));
    end
  end

  // One cycle of stimulus; returns 1ns after the edge that consumed it.
  task automatic send(input logic v, input logic [WIDTH-1:0] d, input logic c, input logic f);
    in_valid = v;
    in_data  = d;
    in_check = c;
    flush    = f;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [WIDTH-1:0] w8[8];
    logic [WIDTH-1:0] wg[4];
    int pulses[$];

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_check = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_parity", 32'(out_parity), 32'h0);
    chk("rst_bit", 32'(out_bit), 32'h0);
    chk("rst_err", 32'(out_err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    idle(1);

    // Generate mode, consecutive words.
    send(1'b1, 8'h01, 1'b0, 1'b0);
    send(1'b1, 8'h02, 1'b0, 1'b0);
    send(1'b1, 8'h04, 1'b0, 1'b0);
    send(1'b1, 8'h08, 1'b0, 1'b0);
    chk("gen_valid", 32'(out_valid), 32'h1);
    chk("gen_parity", 32'(out_parity), 32'h0F);
    chk("gen_bit", 32'(out_bit), 32'h0);
    chk("gen_err", 32'(out_err), 32'h0);
    idle(1);
    chk("gen_pulse_end", 32'(out_valid), 32'h0);
    chk("gen_hold", 32'(out_parity), 32'h0F);

    // Check mode, good trailer; mid-frame in_check changes are ignored.
    send(1'b1, 8'h01, 1'b1, 1'b0);
    send(1'b1, 8'h02, 1'b0, 1'b0);
    send(1'b1, 8'h04, 1'b0, 1'b0);
    send(1'b1, 8'h08, 1'b0, 1'b0);
    chk("chk_no_early", 32'(out_valid), 32'h0);
    send(1'b1, 8'h0F, 1'b0, 1'b0);
    chk("chk_ok_valid", 32'(out_valid), 32'h1);
    chk("chk_ok_parity", 32'(out_parity), 32'h00);
    chk("chk_ok_err", 32'(out_err), 32'h0);

    // Check mode, bad trailer.
    send(1'b1, 8'h01, 1'b1, 1'b0);
    send(1'b1, 8'h02, 1'b1, 1'b0);
    send(1'b1, 8'h04, 1'b1, 1'b0);
    send(1'b1, 8'h08, 1'b1, 1'b0);
    send(1'b1, 8'h0E, 1'b1, 1'b0);
    chk("chk_bad_parity", 32'(out_parity), 32'h01);
    chk("chk_bad_err", 32'(out_err), 32'h1);
    chk("chk_bad_bit", 32'(out_bit), 32'h1);
    idle(2);

    // Generate mode with random gaps between words.
    wg[0] = 8'h01; wg[1] = 8'h02; wg[2] = 8'h04; wg[3] = 8'h08;
    for (int w = 0; w < 4; w++) begin
      send(1'b1, wg[w], 1'b0, 1'b0);
      if (w < 3) begin
        chk("gap_busy", 32'(busy), 32'h1);
        idle(int'($urandom_range(0, 3)));
        chk("gap_busy_idle", 32'(busy), 32'h1);
      end
    end
    chk("gap_parity", 32'(out_parity), 32'h0F);
    chk("gap_valid", 32'(out_valid), 32'h1);
    chk("gap_busy_done", 32'(busy), 32'h0);
    idle(1);

    // Two back-to-back frames.
    w8[0] = 8'hFF; w8[1] = 8'h00; w8[2] = 8'h00; w8[3] = 8'h00;
    w8[4] = 8'hAA; w8[5] = 8'h55; w8[6] = 8'h00; w8[7] = 8'h00;
    for (int i = 0; i < 8; i++) begin
      send(1'b1, w8[i], 1'b0, 1'b0);
      if (out_valid) begin
        pulses.push_back(i);
        chk("b2b_parity", 32'(out_parity), 32'hFF);
        chk("b2b_bit", 32'(out_bit), 32'h0);
      end
    end
    chk("b2b_pulses", 32'(pulses.size()), 32'd2);
    if (pulses.size() == 2) chk("b2b_spacing", 32'(pulses[1] - pulses[0]), 32'd4);
    idle(1);

    // Flush after two words, then a fresh frame.
    send(1'b1, 8'h3C, 1'b0, 1'b0);
    send(1'b1, 8'hC3, 1'b0, 1'b0);
    send(1'b0, 8'h00, 1'b0, 1'b1);
    chk("flush_busy", 32'(busy), 32'h0);
    chk("flush_valid", 32'(out_valid), 32'h0);
    send(1'b1, 8'h10, 1'b0, 1'b0);
    send(1'b1, 8'h20, 1'b0, 1'b0);
    send(1'b1, 8'h40, 1'b0, 1'b0);
    send(1'b1, 8'h80, 1'b0, 1'b0);
    chk("flush_frame_valid", 32'(out_valid), 32'h1);
    chk("flush_frame_parity", 32'(out_parity), 32'hF0);

    // Flush together with in_valid discards the word.
    send(1'b1, 8'h33, 1'b0, 1'b1);
    chk("flush_vld_busy", 32'(busy), 32'h0);
    idle(1);

    // Reset mid-frame clears outputs without a clock edge.
    send(1'b1, 8'h11, 1'b0, 1'b0);
    send(1'b1, 8'h22, 1'b0, 1'b0);
    send(1'b1, 8'h44, 1'b0, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    chk("mrst_valid", 32'(out_valid), 32'h0);
    chk("mrst_parity", 32'(out_parity), 32'h0);
    chk("mrst_bit", 32'(out_bit), 32'h0);
    chk("mrst_err", 32'(out_err), 32'h0);
    chk("mrst_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(1'b1, 8'h01, 1'b0, 1'b0);
    send(1'b1, 8'h02, 1'b0, 1'b0);
    send(1'b1, 8'h04, 1'b0, 1'b0);
    send(1'b1, 8'h08, 1'b0, 1'b0);
    chk("mrst_frame_valid", 32'(out_valid), 32'h1);
    chk("mrst_frame_parity", 32'(out_parity), 32'h0F);

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 600; i++) begin
      send(1'($urandom_range(0, 3) != 0), WIDTH'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xor_frame_parity.md
# xor_frame_parity

Parametrised streaming XOR parity unit, the clocked successor to the single-bit XOR gate. It accumulates the bitwise XOR of a frame of WIDTH-bit words and reports the column parity plus a scalar parity bit. In check mode it compares the accumulated parity against a trailing parity word and flags mismatches. It sits between a word source and any downstream integrity logic, at full throughput with no backpressure.

## Interface
- WIDTH, 8: data word width in bits; must be ≥1.
- FRAME_LEN, 4: data words per frame; must be ≥1.
- ODD, 0: 0 selects even scalar parity, 1 selects odd.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  a word is presented this cycle.
- in_data  in  WIDTH  data word.
- in_check  in  1  mode select: 0 = generate, 1 = check. Sampled only on the first word of a frame.
- flush  in  1  synchronous abort of the current frame.
- out_valid  out  1  one-cycle pulse; result registers are valid.
- out_parity  out  WIDTH  column XOR of the frame.
- out_bit  out  1  reduction XOR of out_parity, XOR ODD.
- out_err  out  1  check mode only: 1 if out_parity ≠ 0.
- busy  out  1  a frame is partially accumulated.

## Operation
- Internal state:
  - accumulator acc[WIDTH-1:0];
  - word counter cnt, width $clog2(FRAME_LEN+2);
  - latched mode bit mode_q.
- FSM has two states:
  - IDLE (cnt=0).
  - ACCUM (cnt≥1).
- IDLE behaviour:
  - On an accepted word (in_valid=1, flush=0): acc←in_data, cnt←1, mode_q←in_check, go to ACCUM.
  - Special case: if the frame length is 1 (FRAME_LEN=1 and in_check=0), the frame completes immediately. Emit the result and stay in IDLE.
- ACCUM behaviour:
  - On an accepted word: acc←acc^in_data, cnt←cnt+1.
- Frame length:
  - Generate mode: FRAME_LEN words.
  - Check mode: FRAME_LEN+1 words; the final word is the expected parity.
- On the final accepted word of a frame:
  - out_parity←acc^in_data;
  - out_bit←^(acc^in_data)^ODD;
  - out_err←mode_q & |(acc^in_data);
  - out_valid←1;
  - cnt←0, go to IDLE.
- Result registers hold their value until the next frame completes. Only out_valid returns to 0.
- in_valid=0: no state change; gaps of any length are allowed.
- flush=1: cnt←0, acc←0, go to IDLE, out_valid←0. flush wins over a simultaneous in_valid, and that word is discarded.
- in_check changes mid-frame are ignored.
- busy is combinationally equal to (cnt≠0).
- In generate mode out_err is always 0.

## Timing
- Reset values: out_valid=0, out_parity=0, out_bit=0, out_err=0, busy=0, acc=0, cnt=0, state IDLE. All take effect immediately on rst assertion, without waiting for a clock edge.
- Latency: the final word is accepted at edge k; out_valid is high from edge k to edge k+1, exactly one cycle.
- Back-to-back frames: the first word of the next frame may be accepted at edge k+1. Sustained throughput is one word per cycle.
- out_valid never stays asserted for two consecutive cycles, except when FRAME_LEN=1 in generate mode with continuous input.
- Reset mid-frame discards the partial frame. There is no output pulse for the discarded frame.

## Structure
- Shared package xor_pkg holds:
  - the state enum (IDLE, ACCUM);
  - the function cnt_width(FRAME_LEN);
  - the mode constants MODE_GEN=0 and MODE_CHK=1.
- One natural sub-module is xor_reduce. It is a parametrised WIDTH-input reduction XOR used for out_bit, and it is reusable elsewhere in the gate library.

## Test plan
All scenarios use WIDTH=8, FRAME_LEN=4, ODD=0.
- Generate mode, words 0x01, 0x02, 0x04, 0x08 on consecutive cycles -> one-cycle out_valid after the 4th edge; out_parity=0x0F, out_bit=0, out_err=0.
- Check mode, words 0x01, 0x02, 0x04, 0x08, 0x0F -> out_parity=0x00, out_err=0. Repeat with a last word of 0x0E -> out_parity=0x01, out_err=1, out_bit=1.
- Generate mode with random in_valid gaps (0–3 idle cycles between words), words 0x01, 0x02, 0x04, 0x08 -> identical result to the first scenario. busy=1 from the 1st to the 4th edge.
- Eight back-to-back words 0xFF, 0x00, 0x00, 0x00, 0xAA, 0x55, 0x00, 0x00 -> two out_valid pulses exactly 4 cycles apart, each with out_parity=0xFF and out_bit=0.
- Flush and reset:
  - Flush after 2 words, then a fresh frame 0x10, 0x20, 0x40, 0x80 -> out_parity=0xF0, with no pulse for the aborted frame.
  - flush together with in_valid -> that word is ignored and busy=0 on the next cycle.
- Reset mid-frame: assert rst between edges after 3 words -> all outputs 0 immediately. After release, a full frame of 0x01, 0x02, 0x04, 0x08 yields 0x0F.
